// File: rtl/cache_ctrl_nway_if.sv
// cache_ctrl_nway_if: request/response and backing-memory bus of the N-way cache controller.
//   slave  : cache side (accepts requests, answers, drives the memory request)
//   master : requester/memory side (issues requests, answers memory requests)
//   req_*  : request handshake (valid/ready, write flag, word address, write data)
//   resp_* : one-cycle completion pulse with read data or the written word
//   mem_*  : single-word backing-memory access, completed by mem_ack
interface cache_ctrl_nway_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: WAYS-way set-associative, write-back / write-allocate cache controller,
// one DATA_WIDTH word per line, round-robin replacement after invalid ways are used up.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : cache_ctrl_nway_if.slave (request, response and backing-memory signals)
//   hit_count  : saturating LOOKUP hit counter   (only with CACHE_STATS_EN defined)
//   miss_count : saturating LOOKUP miss counter  (only with CACHE_STATS_EN defined)
// Optional feature macro: CACHE_STATS_EN.
module cache_ctrl_nway #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INDEX_WIDTH = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int WAYS        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_ctrl_nway_if.slave      bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {StIdle, StLookup, StWriteback, StRefill} state_e;

    state_e                r_state;
    logic [WAYS-1:0]       r_valid [SETS];
    logic [WAYS-1:0]       r_dirty [SETS];
    logic [WAY_W-1:0]      r_rr    [SETS];
    logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS];

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [WAY_W-1:0]      r_victim;

    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
`ifdef CACHE_STATS_EN
    logic [31:0]           r_hit_count;
    logic [31:0]           r_miss_count;
`endif

    logic [INDEX_WIDTH-1:0] w_index;
    logic [TAG_W-1:0]       w_req_tag;
    logic                   w_hit;
    logic [WAY_W-1:0]       w_hit_way;
    logic                   w_has_invalid;
    logic [WAY_W-1:0]       w_inv_way;
    logic [WAY_W-1:0]       w_victim;
    logic                   w_hit_write;
    logic                   w_fill;

    assign w_index   = r_addr[INDEX_WIDTH-1:0];
    assign w_req_tag = r_addr[ADDR_WIDTH-1:INDEX_WIDTH];

    // Scan from the top way down so the lowest-numbered match / invalid way wins.
    always_comb begin
        w_hit         = 1'b0;
        w_hit_way     = '0;
        w_has_invalid = 1'b0;
        w_inv_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_index][w]) begin
                w_has_invalid = 1'b1;
                w_inv_way     = WAY_W'(w);
            end
        end
        w_victim = w_has_invalid ? w_inv_way : r_rr[w_index];
    end

    assign w_hit_write = (r_state == StLookup) && w_hit && r_write;
    // mem_ack only counts while our request is actually up.
    assign w_fill      = (r_state == StRefill) && r_mem_req && bus.mem_ack;

    // Tag and data storage need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_hit_write) begin
            r_data[w_index][w_hit_way] <= r_wdata;
        end
        if (w_fill) begin
            r_tag[w_index][r_victim]  <= w_req_tag;
            r_data[w_index][r_victim] <= r_write ? r_wdata : bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_victim     <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
`ifdef CACHE_STATS_EN
            r_hit_count  <= '0;
            r_miss_count <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= StLookup;
                    end
                end
                StLookup: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_write ? r_wdata : r_data[w_index][w_hit_way];
                        if (r_write) begin
                            r_dirty[w_index][w_hit_way] <= 1'b1;
                        end
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
`ifdef CACHE_STATS_EN
                        if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
`endif
                    end else begin
                        r_victim  <= w_victim;
                        r_mem_req <= 1'b1;
                        if (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim]) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_index][w_victim], w_index};
                            r_mem_wdata <= r_data[w_index][w_victim];
                            r_state     <= StWriteback;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= r_addr;
                            r_state    <= StRefill;
                        end
`ifdef CACHE_STATS_EN
                        if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
`endif
                    end
                end
                StWriteback: begin
                    // Drop mem_req for one cycle after the ack so the refill is a fresh request.
                    if (bus.mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                        r_state    <= StRefill;
                    end
                end
                StRefill: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (bus.mem_ack) begin
                        r_mem_req                  <= 1'b0;
                        r_valid[w_index][r_victim] <= 1'b1;
                        r_dirty[w_index][r_victim] <= r_write;
                        r_rr[w_index]              <= r_rr[w_index] + 1'b1;
                        r_resp_valid               <= 1'b1;
                        r_resp_rdata               <= r_write ? r_wdata : bus.mem_rdata;
                        r_req_ready                <= 1'b1;
                        r_state                    <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
`ifdef CACHE_STATS_EN
    assign hit_count      = r_hit_count;
    assign miss_count     = r_miss_count;
`endif
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb_cache_ctrl_nway: directed scenarios plus randomized traffic for cache_ctrl_nway, checked
// against an architectural memory image and a line-address-level cache occupancy model.
// Honours CACHE_STATS_EN to also check the hit/miss counters.
module tb_cache_ctrl_nway;
    localparam int AW   = 12;
    localparam int IW   = 6;
    localparam int DW   = 32;
    localparam int WAYS = 4;
    localparam int SETS = 1 << IW;
    localparam int MEMW = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_nway_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_ctrl_nway #(
        .ADDR_WIDTH (AW),
        .INDEX_WIDTH(IW),
        .DATA_WIDTH (DW),
        .WAYS       (WAYS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Backing memory (what the memory holds) and architectural image (what a read must return).
    logic [DW-1:0] mem  [MEMW];
    logic [DW-1:0] arch [MEMW];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_txn_t;
    mem_txn_t mem_log[$];

    int mem_lat      = 0;
    bit mem_lat_rand = 1'b0;
    int mreq_cycles  = 0;

    // Memory responder: acks after a programmable number of cycles with mem_req high.
    initial begin
        int lat_left;
        lat_left     = -1;
        bus.mem_ack  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = DW'($urandom);
            if (rst || !bus.mem_req) begin
                lat_left = -1;
            end else begin
                if (lat_left < 0) lat_left = mem_lat_rand ? int'($urandom_range(0, 4)) : mem_lat;
                if (lat_left == 0) begin
                    mem_txn_t t;
                    t.we   = bus.mem_we;
                    t.addr = bus.mem_addr;
                    t.data = bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr];
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                    else            bus.mem_rdata     = mem[bus.mem_addr];
                    mem_log.push_back(t);
                    bus.mem_ack = 1'b1;
                    lat_left    = -1;
                end else begin
                    lat_left--;
                end
            end
        end
    end

    always @(posedge clk) if (bus.mem_req) mreq_cycles++;

    // Writeback monitor: every cycle of a write request must present the expected victim.
    logic          exp_wb_valid = 1'b0;
    logic [AW-1:0] exp_wb_addr  = '0;
    logic [DW-1:0] exp_wb_data  = '0;
    int            wb_cycles    = 0;
    always @(negedge clk) begin
        if (!rst && bus.mem_req && bus.mem_we) begin
            wb_cycles++;
            check("wb_expected", 1'b1, exp_wb_valid);
            check("wb_req_ready", bus.req_ready, 1'b0);
            if (exp_wb_valid) begin
                check("wb_addr", bus.mem_addr, exp_wb_addr);
                check("wb_data", bus.mem_wdata, exp_wb_data);
            end
        end
    end

    // Occupancy model: per set, which line addresses are held and whether they are dirty.
    logic          m_valid [SETS][WAYS];
    logic          m_dirty [SETS][WAYS];
    logic [AW-1:0] m_line  [SETS][WAYS];
    int            m_rr    [SETS];
    int            m_hits;
    int            m_misses;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_line[s][w]  = '0;
            end
        end
        m_hits   = 0;
        m_misses = 0;
        // Dirty data held only in the cache is lost by a reset.
        for (int a = 0; a < MEMW; a++) arch[a] = mem[a];
    endtask

    task automatic model_access(input logic wr, input logic [AW-1:0] addr, output logic hit,
                                output logic wb, output logic [AW-1:0] wb_addr);
        int s, way, victim;
        s = int'(addr) % SETS;
        way = -1;
        wb = 1'b0;
        wb_addr = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way < 0 && m_valid[s][w] && m_line[s][w] == addr) way = w;
        end
        hit = (way >= 0);
        if (hit) begin
            m_hits++;
            if (wr) m_dirty[s][way] = 1'b1;
        end else begin
            m_misses++;
            victim = -1;
            for (int w = 0; w < WAYS; w++) if (victim < 0 && !m_valid[s][w]) victim = w;
            if (victim < 0) victim = m_rr[s];
            wb      = m_valid[s][victim] && m_dirty[s][victim];
            wb_addr = m_line[s][victim];
            m_valid[s][victim] = 1'b1;
            m_dirty[s][victim] = wr;
            m_line[s][victim]  = addr;
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output int lat);
        int guard;
        mem_log.delete();
        mreq_cycles   = 0;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat   = 1;
        guard = 0;
        while (!bus.resp_valid && guard < 500) begin
            @(posedge clk); #1;
            lat++;
            guard++;
        end
        check("resp_arrived", bus.resp_valid, 1'b1);
        rd = bus.resp_rdata;
    endtask

    task automatic run_op(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        logic          hit, wb;
        logic [AW-1:0] wba;
        logic [DW-1:0] rd, exp_rd;
        int            lat, n_exp;
        model_access(wr, addr, hit, wb, wba);
        exp_wb_valid = wb;
        exp_wb_addr  = wba;
        exp_wb_data  = arch[wba];
        do_req(wr, addr, wd, rd, lat);
        exp_rd = wr ? wd : arch[addr];
        if (wr) arch[addr] = wd;
        n_exp = hit ? 0 : (wb ? 2 : 1);
        check("resp_rdata", rd, exp_rd);
        check("mem_txns", mem_log.size(), n_exp);
        if (hit) begin
            check("hit_latency", lat, 2);
            check("hit_no_mem_req", mreq_cycles, 0);
        end else if (mem_log.size() == n_exp) begin
            check("refill_we", mem_log[n_exp-1].we, 1'b0);
            check("refill_addr", mem_log[n_exp-1].addr, addr);
            if (wb) begin
                check("wb_log_addr", mem_log[0].addr, wba);
                check("wb_log_we", mem_log[0].we, 1'b1);
            end
        end
        exp_wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, '0);
        check({tag, "_mem_req"}, bus.mem_req, 1'b0);
        check({tag, "_mem_we"}, bus.mem_we, 1'b0);
        check({tag, "_mem_addr"}, bus.mem_addr, '0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
`ifdef CACHE_STATS_EN
        check({tag, "_hit_count"}, hit_count, '0);
        check({tag, "_miss_count"}, miss_count, '0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] wd, rd;
        logic [AW-1:0] a;
        int            g, lat;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < MEMW; i++) mem[i] = (DW'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
        mem[12'h040] = 32'hDEAD_BEEF;

        do_reset();
        check_reset_outputs("reset");

        // Cold read miss, then hit on the same word.
        run_op(1'b0, 12'h040, '0);
        run_op(1'b0, 12'h040, '0);

        // Write-allocate miss then read back.
        run_op(1'b1, 12'h080, 32'h1234_5678);
        run_op(1'b0, 12'h080, '0);

        // Fill set 1 with dirty lines, then evict way 0 with a slow memory.
        run_op(1'b1, 12'h001, 32'h0000_1001);
        run_op(1'b1, 12'h041, 32'h0000_1041);
        run_op(1'b1, 12'h081, 32'h0000_1081);
        run_op(1'b1, 12'h0C1, 32'h0000_10C1);
        mem_lat   = 6;
        wb_cycles = 0;
        run_op(1'b1, 12'h101, 32'h0000_1101);
        mem_lat   = 0;
        check("wb_hold_cycles", wb_cycles, 7);
        check("wb_victim_addr", (mem_log.size() > 0) ? mem_log[0].addr : 12'hFFF, 12'h001);
        check("wb_victim_data", (mem_log.size() > 0) ? mem_log[0].data : 32'h0, 32'h0000_1001);

        // Reset in the middle of a refill; previously cached 0x040 must miss afterwards.
        run_op(1'b0, 12'h040, '0);
        mem_lat       = 20;
        bus.req_write = 1'b0;
        bus.req_addr  = 12'h200;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        g = 0;
        while (!(bus.mem_req && !bus.mem_we) && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("refill_started", bus.mem_req, 1'b1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mem_lat = 0;
        run_op(1'b0, 12'h040, '0);

        // Two misses and three hits from a clean start.
        do_reset();
        run_op(1'b0, 12'h300, '0);
        run_op(1'b0, 12'h301, '0);
        run_op(1'b0, 12'h300, '0);
        run_op(1'b1, 12'h300, 32'hCAFE_0300);
        run_op(1'b0, 12'h301, '0);
`ifdef CACHE_STATS_EN
        check("stats_hits", hit_count, 32'd3);
        check("stats_misses", miss_count, 32'd2);
`endif

        // Random traffic over a few conflicting sets with random memory latency.
        mem_lat_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            a  = AW'(($urandom_range(0, 7) << IW) | $urandom_range(0, 3));
            wd = DW'($urandom);
            run_op(1'($urandom_range(0, 1)), a, wd);
        end
        mem_lat_rand = 1'b0;
        // Read back every word the random phase may have touched.
        for (int t = 0; t < 8; t++) begin
            for (int s = 0; s < 4; s++) begin
                run_op(1'b0, AW'((t << IW) | s), '0);
            end
        end
`ifdef CACHE_STATS_EN
        check("stats_hits_total", hit_count, 32'(m_hits));
        check("stats_misses_total", miss_count, 32'(m_misses));
`endif
        rd = '0;
        lat = 0;
        if (rd != '0 || lat != 0) $display("unexpected local state");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
